// File: rtl/cic_comp_pkg.sv
// Shared types and coefficients for the CIC compensation decimator.
package cic_comp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_t;

  // Unique half of the symmetric Q1.15 impulse response; index 7 is the centre tap.
  function automatic coef_t coef_at(input int unsigned k);
    coef_t c;
    case (k)
      0:       c = -16'sd64;
      1:       c = 16'sd0;
      2:       c = 16'sd320;
      3:       c = 16'sd0;
      4:       c = -16'sd1280;
      5:       c = 16'sd0;
      6:       c = 16'sd9216;
      7:       c = 16'sd16384;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cic_comp_round_sat.sv
// Round half-up and saturate a wide signed accumulator down to OUT_W bits.
module cic_comp_round_sat #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned FRAC  = 15,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y_c
);

  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (FRAC - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    biased  = (ACC_W+1)'(acc) + HALF;
    shifted = biased >>> FRAC;
    if (shifted > SAT_MAX) begin
      y_c = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      y_c = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      y_c = OUT_W'(shifted);
    end
  end

endmodule

// File: rtl/cic_comp_fir_decim2.sv
// Symmetric compensation FIR after the CIC, decimating by 2 with one shared multiplier.
module cic_comp_fir_decim2
  import cic_comp_pkg::*;
#(
  parameter int unsigned NTAPS     = 15,
  parameter int unsigned COEF_FRAC = 15,
  parameter int unsigned ACC_W     = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] din,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] dout,
  output logic                     overflow
);

  localparam int unsigned NUNIQ  = (NTAPS + 1) / 2;
  localparam int unsigned PTR_W  = $clog2(NTAPS);
  localparam int unsigned K_W    = (NUNIQ > 1) ? $clog2(NUNIQ) : 1;
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUNIQ - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NTAPS - 1);

  logic signed [DATA_W-1:0] dline [NTAPS];
  logic [PTR_W-1:0]         wr_ptr;
  logic                     phase;

  state_t                   state, state_d;
  logic [K_W-1:0]           k, k_d;
  logic signed [ACC_W-1:0]  acc, acc_d;
  logic                     pend_vld, pend_vld_d;
  logic signed [DATA_W-1:0] pend_data, pend_data_d;
  logic                     valid_out_d, overflow_d;
  logic signed [DATA_W-1:0] dout_d;

  logic                     commit_c;
  logic signed [DATA_W-1:0] commit_data_c;
  logic [PTR_W-1:0]         idx_new_c, idx_old_c;
  coef_t                    coef_c;
  logic signed [PRE_W-1:0]  pre_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [DATA_W-1:0] y_sat_c;

  // Circular index arithmetic; base + off never exceeds 2*NTAPS-2.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NTAPS) s = s - NTAPS;
    return PTR_W'(s);
  endfunction

  // Pre-add the mirrored tap pair for step k; the centre tap goes in alone.
  always_comb begin
    idx_new_c = ptr_add(wr_ptr, NTAPS - 1 - 32'(k));
    idx_old_c = ptr_add(wr_ptr, 32'(k));
    coef_c    = coef_at(32'(k));
    if (k == K_LAST) begin
      pre_c = PRE_W'(dline[idx_new_c]);
    end else begin
      pre_c = PRE_W'(dline[idx_new_c]) + PRE_W'(dline[idx_old_c]);
    end
    prod_c = PROD_W'(pre_c) * PROD_W'(coef_c);
  end

  cic_comp_round_sat #(
    .ACC_W (ACC_W),
    .FRAC  (COEF_FRAC),
    .OUT_W (DATA_W)
  ) u_round_sat (
    .acc (acc),
    .y_c (y_sat_c)
  );

  // Next-state: sample admission, pending slot, MAC sequencing and output update.
  always_comb begin
    state_d       = state;
    k_d           = k;
    acc_d         = acc;
    pend_vld_d    = pend_vld;
    pend_data_d   = pend_data;
    valid_out_d   = 1'b0;
    dout_d        = dout;
    overflow_d    = overflow;
    commit_c      = 1'b0;
    commit_data_c = din;

    case (state)
      IDLE: begin
        if (valid_in) begin
          commit_c      = 1'b1;
          commit_data_c = din;
        end
      end
      MAC: begin
        acc_d = acc + ACC_W'(prod_c);
        k_d   = k + K_W'(1);
        if (k == K_LAST) state_d = ROUND;
        if (valid_in) begin
          if (!pend_vld) begin
            pend_vld_d  = 1'b1;
            pend_data_d = din;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ROUND: begin
        dout_d      = y_sat_c;
        valid_out_d = 1'b1;
        state_d     = IDLE;
        if (pend_vld) begin
          commit_c      = 1'b1;
          commit_data_c = pend_data;
          pend_vld_d    = valid_in;
          if (valid_in) pend_data_d = din;
        end else if (valid_in) begin
          commit_c      = 1'b1;
          commit_data_c = din;
        end
      end
      default: state_d = IDLE;
    endcase

    // An odd-phase commit launches a fresh output computation.
    if (commit_c && phase) begin
      state_d = MAC;
      k_d     = '0;
      acc_d   = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      valid_out <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      acc       <= acc_d;
      pend_vld  <= pend_vld_d;
      pend_data <= pend_data_d;
      valid_out <= valid_out_d;
      dout      <= dout_d;
      overflow  <= overflow_d;
    end
  end

  // Delay line: a commit overwrites the oldest entry and flips the decimation phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
      wr_ptr <= '0;
      phase  <= 1'b0;
    end else if (commit_c) begin
      dline[wr_ptr] <= commit_data_c;
      wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      phase         <= ~phase;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir_decim2.sv
// Self-checking bench: random and directed streams against a convolution model.
module tb_cic_comp_fir_decim2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic signed [15:0] din = '0;
  logic valid_out;
  logic signed [15:0] dout;
  logic overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  localparam int C [15] = '{-64, 0, 320, 0, -1280, 0, 9216, 16384,
                            9216, 0, -1280, 0, 320, 0, -64};

  typedef struct { int val; int due; } exp_t;
  int   hist[$];
  exp_t expq[$];
  int   got[$];
  exp_t head;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comp_fir_decim2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout      (dout),
    .overflow  (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct-form convolution over every accepted sample, rounded and clamped.
  function automatic int model_out();
    longint a = 0;
    int n = hist.size();
    for (int j = 0; j < 15; j++)
      if (n - 1 - j >= 0) a += longint'(C[j]) * longint'(hist[n-1-j]);
    a = (a + 64'sd16384) >>> 15;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    return int'(a);
  endfunction

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : 99999;
  endfunction

  function automatic int rnd_sample();
    logic signed [15:0] r;
    case ($urandom_range(0, 7))
      0:       r = 16'sh7fff;
      1:       r = 16'sh8000;
      default: r = 16'($urandom);
    endcase
    return int'(r);
  endfunction

  // Compare every output pulse with the model, in order and (when known) on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        got.push_back(int'(dout));
        if (expq.size() > 0) begin
          head = expq.pop_front();
          check("dout_vs_model", int'(dout), head.val);
          if (head.due >= 0) check("valid_out_cycle", cyc, head.due);
        end else begin
          check("spurious_valid_out", expq.size(), 1);
        end
      end
      if (expq.size() > 0 && expq[0].due >= 0 && expq[0].due < cyc) begin
        check("missed_valid_out", cyc, expq[0].due);
        void'(expq.pop_front());
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one sample for one cycle; the model learns it unless it is meant to be dropped.
  task automatic send(input int s, input bit timed, input bit drop);
    valid_in = 1'b1;
    din      = 16'(s);
    if (!drop) begin
      hist.push_back(s);
      if (hist.size() % 2 == 0) expq.push_back('{model_out(), timed ? cyc + 10 : -1});
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic stream(input int s, input int g);
    send(s, 1'b1, 1'b0);
    gap(g - 1);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    din      = '0;
    rst_n    = 1'b0;
    gap(2);
    hist.delete();
    expq.delete();
    got.delete();
    check("rst_dout", int'(dout), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    gap(1);
  endtask

  task automatic drain(input string name);
    gap(16);
    check(name, expq.size(), 0);
  endtask

  task automatic impulse_odd();
    int lit [10] = '{-64, 320, -1280, 9216, 9216, -1280, 320, -64, 0, 0};
    for (int i = 0; i < 20; i++) stream((i == 1) ? 32767 : 0, 12);
    drain("imp_odd_drain");
    check("imp_odd_count", got.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("imp_odd_y%0d", i), got_at(i), lit[i]);
  endtask

  initial begin
    int lit_even [8] = '{0, 0, 0, 16384, 0, 0, 0, 0};
    int sgn;

    // Impulse landing on the launching phase.
    do_reset();
    impulse_odd();

    // Impulse on the storing phase: only the centre tap sees it.
    do_reset();
    for (int i = 0; i < 16; i++) stream((i == 0) ? 32767 : 0, 12);
    drain("imp_even_drain");
    check("imp_even_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("imp_even_y%0d", i), got_at(i), lit_even[i]);

    // DC gain of exactly one once the line is full.
    do_reset();
    for (int i = 0; i < 40; i++) stream(1000, 12);
    drain("dc_drain");
    check("dc_count", got.size(), 20);
    for (int i = 7; i < 20; i++) check($sformatf("dc_y%0d", i), got_at(i), 1000);

    // Saturation with tap signs matched, then negated.
    for (int pass = 0; pass < 2; pass++) begin
      sgn = (pass == 0) ? 1 : -1;
      do_reset();
      stream(0, 12);
      for (int j = 14; j >= 0; j--)
        stream((C[j] > 0) ? sgn * 32767 : ((C[j] < 0) ? -sgn * 32767 : 0), 12);
      drain("sat_drain");
      check(pass == 0 ? "sat_pos" : "sat_neg", got_at(7), (pass == 0) ? 32767 : -32768);
    end

    // Busy collisions: one sample parks in pending, then a third is dropped.
    do_reset();
    stream(rnd_sample(), 12);
    send(rnd_sample(), 1'b1, 1'b0);
    gap(1);
    send(rnd_sample(), 1'b0, 1'b0);
    gap(20);
    check("pending_no_overflow", int'(overflow), 0);
    send(rnd_sample(), 1'b1, 1'b0);
    gap(1);
    send(rnd_sample(), 1'b0, 1'b0);
    gap(1);
    send(rnd_sample(), 1'b0, 1'b1);
    gap(20);
    check("overflow_set", int'(overflow), 1);
    for (int i = 0; i < 15; i++) stream(rnd_sample(), 12);
    drain("collide_drain");
    check("overflow_sticky", int'(overflow), 1);

    // Reset during MAC step 3: no output, state fully cleared.
    stream(rnd_sample(), 12);
    send(rnd_sample(), 1'b1, 1'b0);
    gap(3);
    do_reset();
    gap(20);
    check("post_reset_overflow", int'(overflow), 0);
    check("post_reset_no_output", got.size(), 0);
    impulse_odd();

    // Random stream with idle gaps long enough to pin latency.
    do_reset();
    for (int i = 0; i < 120; i++) stream(rnd_sample(), int'($urandom_range(10, 14)));
    drain("rand_timed_drain");

    // Random stream that exercises the pending slot without drops.
    for (int i = 0; i < 120; i++) begin
      send(rnd_sample(), 1'b0, 1'b0);
      gap(int'($urandom_range(4, 8)));
    end
    drain("rand_pend_drain");
    check("rand_no_overflow", int'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
